// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared widths and PC micro-op encodings
package program_counter_pkg;

  localparam int PC_SIZE                   = 8;
  localparam int INSTRUCTION_MEMORY_SIZE   = 256;
  localparam int PC_MICRO_INSTRUCTION_SIZE = 3;

  typedef enum logic [PC_MICRO_INSTRUCTION_SIZE-1:0] {
    PC_NOP  = 3'b000,
    PC_INC  = 3'b001,
    PC_JMP  = 3'b010,
    PC_JZ   = 3'b011,
    PC_JC   = 3'b100,
    PC_CALL = 3'b101,
    PC_RET  = 3'b110,
    PC_CLR  = 3'b111
  } pc_op_e;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - parameterised return-address LIFO with top-of-stack output
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   sp_m1;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_m1   = sp_q - SPW'(1);
  assign top_o   = mem_q[sp_m1[AW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (clr_i)                  sp_d = '0;
    else if (push_i && !full_o) sp_d = sp_q + SPW'(1);
    else if (pop_i && !empty_o) sp_d = sp_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Contents are don't-care after reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clr_i) mem_q[sp_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch PC with call/return stack; PC_HALT_ON_END_EN enables halt at end of memory
module program_counter
  import program_counter_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int MEM_DEPTH   = INSTRUCTION_MEMORY_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PC_MICRO_INSTRUCTION_SIZE-1:0] pc_instruction,
  input  logic [PC_SIZE-1:0]                   target,
  input  logic                                 zero_flag,
  input  logic                                 carry_flag,
  output logic [PC_SIZE-1:0]                   pc,
  output logic                                 stack_err,
  output logic                                 halted
);

`ifdef PC_HALT_ON_END_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [PC_SIZE-1:0] END_ADDR = PC_SIZE'(MEM_DEPTH - 1);

  logic [PC_SIZE-1:0] pc_q, pc_d, pc_inc, rs_top;
  logic               err_q, err_d, halt_q, halt_d;
  logic               rs_push, rs_pop, rs_clr, rs_full, rs_empty;
  logic               adv, at_end;
  pc_op_e             op;

  assign op        = pc_op_e'(pc_instruction);
  assign pc_inc    = pc_q + PC_SIZE'(1);
  assign at_end    = HALT_EN && (pc_q == END_ADDR);
  assign pc        = pc_q;
  assign stack_err = err_q;
  assign halted    = HALT_EN ? halt_q : 1'b0;

  return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(PC_SIZE)) u_return_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (rs_clr),
    .push_i  (rs_push),
    .pop_i   (rs_pop),
    .data_i  (pc_inc),
    .top_o   (rs_top),
    .full_o  (rs_full),
    .empty_o (rs_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    err_d   = err_q;
    halt_d  = halt_q;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    rs_clr  = 1'b0;
    adv     = 1'b0;
    // A halted PC only listens for PC_CLR.
    if (!halt_q || op == PC_CLR) begin
      case (op)
        PC_NOP: ;
        PC_INC: adv = 1'b1;
        PC_JMP: pc_d = target;
        PC_JZ:  if (zero_flag)  pc_d = target; else adv = 1'b1;
        PC_JC:  if (carry_flag) pc_d = target; else adv = 1'b1;
        PC_CALL: begin
          if (!rs_full) begin
            rs_push = 1'b1;
            pc_d    = target;
          end else begin
            err_d = 1'b1;
          end
        end
        PC_RET: begin
          if (!rs_empty) begin
            rs_pop = 1'b1;
            pc_d   = rs_top;
          end else begin
            err_d = 1'b1;
          end
        end
        PC_CLR: begin
          pc_d   = '0;
          err_d  = 1'b0;
          halt_d = 1'b0;
          rs_clr = 1'b1;
        end
        default: ;
      endcase
      if (adv) begin
        if (at_end) halt_d = 1'b1;
        else        pc_d   = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      err_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      err_q  <= err_d;
      halt_q <= halt_d;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;
  import program_counter_pkg::*;

`ifdef PC_HALT_ON_END_EN
  localparam int TB_MEM_DEPTH = 64;
`else
  localparam int TB_MEM_DEPTH = 256;
`endif

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       err;
    logic       halt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pc_instruction = PC_NOP;
  logic [7:0] target = '0;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic [7:0] pc;
  logic       stack_err;
  logic       halted;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  program_counter #(.STACK_DEPTH(4), .MEM_DEPTH(TB_MEM_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_instruction (pc_instruction),
    .target         (target),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .pc             (pc),
    .stack_err      (stack_err),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive one micro-op at the falling edge and queue the state expected after the next rising edge.
  task automatic op(input string tag, input logic [2:0] code, input logic [7:0] tgt,
                    input logic z, input logic c,
                    input logic [7:0] epc, input logic eerr, input logic ehalt);
    exp_t e;
    @(negedge clk);
    pc_instruction = code;
    target         = tgt;
    zero_flag      = z;
    carry_flag     = c;
    e.tag = tag; e.pc = epc; e.err = eerr; e.halt = ehalt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".pc"},   32'(pc),        32'(e.pc));
        check({e.tag, ".err"},  32'(stack_err), 32'(e.err));
        check({e.tag, ".halt"}, 32'(halted),    32'(e.halt));
      end
    end
  end

  task automatic drain;
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    check("reset.pc",   32'(pc),        32'h0);
    check("reset.err",  32'(stack_err), 32'h0);
    check("reset.halt", 32'(halted),    32'h0);
    rst_n = 1'b1;

    op("inc1", PC_INC, 8'h00, 0, 0, 8'h01, 0, 0);
    op("inc2", PC_INC, 8'h00, 0, 0, 8'h02, 0, 0);
    op("inc3", PC_INC, 8'h00, 0, 0, 8'h03, 0, 0);
    op("jmp",  PC_JMP, 8'h40, 0, 0, 8'h40, 0, 0);
    op("jz_nt", PC_JZ, 8'h10, 0, 0, 8'h41, 0, 0);
    op("jc_t",  PC_JC, 8'h20, 0, 1, 8'h20, 0, 0);
    op("jz_t",  PC_JZ, 8'h33, 1, 0, 8'h33, 0, 0);
    op("jc_nt", PC_JC, 8'h10, 1, 0, 8'h34, 0, 0);
    op("nop",  PC_NOP, 8'h99, 1, 1, 8'h34, 0, 0);
    op("clr0", PC_CLR, 8'h55, 0, 0, 8'h00, 0, 0);

    op("jmp05", PC_JMP,  8'h05, 0, 0, 8'h05, 0, 0);
    op("call1", PC_CALL, 8'h30, 0, 0, 8'h30, 0, 0);
    op("call2", PC_CALL, 8'h50, 0, 0, 8'h50, 0, 0);
    op("call3", PC_CALL, 8'h60, 0, 0, 8'h60, 0, 0);
    op("call4", PC_CALL, 8'h70, 0, 0, 8'h70, 0, 0);
    op("call5_ovf", PC_CALL, 8'h99, 0, 0, 8'h70, 1, 0);
    op("ret1", PC_RET, 8'h00, 0, 0, 8'h61, 1, 0);
    op("ret2", PC_RET, 8'h00, 0, 0, 8'h51, 1, 0);
    op("ret3", PC_RET, 8'h00, 0, 0, 8'h31, 1, 0);
    op("ret4", PC_RET, 8'h00, 0, 0, 8'h06, 1, 0);
    op("ret_unf", PC_RET, 8'h00, 0, 0, 8'h06, 1, 0);
    op("clr1", PC_CLR, 8'h00, 0, 0, 8'h00, 0, 0);
    op("ret_unf2", PC_RET, 8'h00, 0, 0, 8'h00, 1, 0);
    op("clr2", PC_CLR, 8'h00, 0, 0, 8'h00, 0, 0);

`ifdef PC_HALT_ON_END_EN
    op("h_jmp_end", PC_JMP, 8'h3F, 0, 0, 8'h3F, 0, 0);
    op("h_inc",     PC_INC, 8'h00, 0, 0, 8'h3F, 0, 1);
    op("h_jmp_ign", PC_JMP, 8'h00, 0, 0, 8'h3F, 0, 1);
    op("h_ret_ign", PC_RET, 8'h00, 0, 0, 8'h3F, 0, 1);
    op("h_clr",     PC_CLR, 8'h00, 0, 0, 8'h00, 0, 0);
    op("h_jmp_end2", PC_JMP, 8'h3F, 0, 0, 8'h3F, 0, 0);
    op("h_jz_nt",    PC_JZ,  8'h10, 0, 0, 8'h3F, 0, 1);
    op("h_clr2",     PC_CLR, 8'h00, 0, 0, 8'h00, 0, 0);
`else
    op("w_jmp_3f", PC_JMP,  8'h3F, 0, 0, 8'h3F, 0, 0);
    op("w_inc_3f", PC_INC,  8'h00, 0, 0, 8'h40, 0, 0);
    op("w_jmp_ff", PC_JMP,  8'hFF, 0, 0, 8'hFF, 0, 0);
    op("w_inc_ff", PC_INC,  8'h00, 0, 0, 8'h00, 0, 0);
    op("w_jmp_ff2", PC_JMP, 8'hFF, 0, 0, 8'hFF, 0, 0);
    op("w_call_ff", PC_CALL, 8'h10, 0, 0, 8'h10, 0, 0);
    op("w_ret",     PC_RET,  8'h00, 0, 0, 8'h00, 0, 0);
`endif

    // Build pc=0x17, stack two deep, stack_err set, then reset asynchronously.
    op("m_clr",   PC_CLR,  8'h00, 0, 0, 8'h00, 0, 0);
    op("m_ret",   PC_RET,  8'h00, 0, 0, 8'h00, 1, 0);
    op("m_call1", PC_CALL, 8'h08, 0, 0, 8'h08, 1, 0);
    op("m_call2", PC_CALL, 8'h16, 0, 0, 8'h16, 1, 0);
    op("m_inc",   PC_INC,  8'h00, 0, 0, 8'h17, 1, 0);
    drain();

    @(negedge clk);
    pc_instruction = PC_NOP;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.pc",  32'(pc),        32'h0);
    check("async_rst.err", 32'(stack_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst_ret", PC_RET, 8'h00, 0, 0, 8'h00, 1, 0);
    op("post_rst_clr", PC_CLR, 8'h00, 0, 0, 8'h00, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
